// File: rtl/fetch_controller.sv
// Instruction fetch sequencer for a synchronous 1-cycle instruction memory.
// It keeps one read in flight, holds a 1-entry skid buffer for decode stalls, and supports redirect and halt.
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        halted
);

    localparam int unsigned     XLEN       = 32;
    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_WORDS);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_inflight_v;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_skid_v;
    logic [XLEN-1:0] r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_id_instr;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_pc_plus4;
    logic            r_id_valid;
    logic            r_halted;

    logic [0:0]      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_inflight_v_nxt;
    logic [XLEN-1:0] w_inflight_pc_nxt;
    logic            w_skid_v_nxt;
    logic [XLEN-1:0] w_skid_instr_nxt;
    logic [XLEN-1:0] w_skid_pc_nxt;
    logic [XLEN-1:0] w_id_instr_nxt;
    logic [XLEN-1:0] w_id_pc_nxt;
    logic [XLEN-1:0] w_id_pc_plus4_nxt;
    logic            w_id_valid_nxt;
    logic            w_halted_nxt;

    logic            w_issue_ok;
    logic            w_src_v;
    logic [XLEN-1:0] w_src_instr;
    logic [XLEN-1:0] w_src_pc;

    // Word index must fall inside the memory before a fetch may be issued.
    assign w_issue_ok = (r_state == ST_RUN) && ({2'b00, r_pc[31:2]} < IMEM_LIMIT);

    // Skid entry is always older than anything that could be in flight.
    always_comb begin
        w_src_v     = 1'b0;
        w_src_instr = imem_instr;
        w_src_pc    = r_inflight_pc;
        if (r_skid_v) begin
            w_src_v     = 1'b1;
            w_src_instr = r_skid_instr;
            w_src_pc    = r_skid_pc;
        end else if (r_inflight_v) begin
            w_src_v = 1'b1;
        end
    end

    // Next-state logic: redirect beats stall, stall beats normal flow.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_inflight_v_nxt  = r_inflight_v;
        w_inflight_pc_nxt = r_inflight_pc;
        w_skid_v_nxt      = r_skid_v;
        w_skid_instr_nxt  = r_skid_instr;
        w_skid_pc_nxt     = r_skid_pc;
        w_id_instr_nxt    = r_id_instr;
        w_id_pc_nxt       = r_id_pc;
        w_id_pc_plus4_nxt = r_id_pc_plus4;
        w_id_valid_nxt    = r_id_valid;
        w_halted_nxt      = r_halted;

        if (redirect) begin
            w_pc_nxt         = redirect_pc & ALIGN_MASK;
            w_inflight_v_nxt = 1'b0;
            w_skid_v_nxt     = 1'b0;
            w_id_valid_nxt   = 1'b0;
            w_state_nxt      = ST_RUN;
            w_halted_nxt     = 1'b0;
        end else if (stall) begin
            // Park the returning read so it is not lost while decode is blocked.
            if (r_inflight_v && !r_skid_v) begin
                w_skid_v_nxt     = 1'b1;
                w_skid_instr_nxt = imem_instr;
                w_skid_pc_nxt    = r_inflight_pc;
            end
            w_inflight_v_nxt = 1'b0;
        end else if (r_state == ST_HALT) begin
            w_id_valid_nxt   = 1'b0;
            w_inflight_v_nxt = 1'b0;
            w_skid_v_nxt     = 1'b0;
        end else begin
            w_skid_v_nxt = 1'b0;
            if (w_src_v && (w_src_instr == HALT_INSTR)) begin
                w_id_valid_nxt   = 1'b0;
                w_state_nxt      = ST_HALT;
                w_halted_nxt     = 1'b1;
                w_inflight_v_nxt = 1'b0;
            end else begin
                if (w_src_v) begin
                    w_id_instr_nxt    = w_src_instr;
                    w_id_pc_nxt       = w_src_pc;
                    w_id_pc_plus4_nxt = w_src_pc + PC_STEP;
                    w_id_valid_nxt    = 1'b1;
                end else begin
                    w_id_valid_nxt = 1'b0;
                end

                if (w_issue_ok) begin
                    w_inflight_v_nxt  = 1'b1;
                    w_inflight_pc_nxt = r_pc;
                    w_pc_nxt          = r_pc + PC_STEP;
                end else begin
                    w_inflight_v_nxt = 1'b0;
                end

                // Ran off the end of memory and nothing left to drain.
                if (!w_issue_ok && !r_inflight_v && !r_skid_v) begin
                    w_state_nxt  = ST_HALT;
                    w_halted_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
            r_skid_v      <= 1'b0;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
            r_id_instr    <= '0;
            r_id_pc       <= '0;
            r_id_pc_plus4 <= '0;
            r_id_valid    <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_inflight_v  <= w_inflight_v_nxt;
            r_inflight_pc <= w_inflight_pc_nxt;
            r_skid_v      <= w_skid_v_nxt;
            r_skid_instr  <= w_skid_instr_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_id_instr    <= w_id_instr_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_pc_plus4 <= w_id_pc_plus4_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    assign imem_pc     = r_pc;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign id_valid    = r_id_valid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a default-depth instance and a 4-word instance,
// each with its own 1-cycle memory model, expected-PC queue and consumption monitor.
module tb_fetch_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, stall_a, redirect_a, id_valid_a, halted_a;
    logic [31:0] redirect_pc_a, imem_pc_a, imem_instr_a, id_instr_a, id_pc_a, id_pc_plus4_a;
    logic        reset_b, stall_b, redirect_b, id_valid_b, halted_b;
    logic [31:0] redirect_pc_b, imem_pc_b, imem_instr_b, id_instr_b, id_pc_b, id_pc_plus4_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    bit halt_en = 1'b0;

    fetch_controller u_dut_a (
        .clk(clk), .reset(reset_a), .stall(stall_a), .redirect(redirect_a),
        .redirect_pc(redirect_pc_a), .imem_pc(imem_pc_a), .imem_instr(imem_instr_a),
        .id_instr(id_instr_a), .id_pc(id_pc_a), .id_pc_plus4(id_pc_plus4_a),
        .id_valid(id_valid_a), .halted(halted_a)
    );

    fetch_controller #(.IMEM_WORDS(4)) u_dut_b (
        .clk(clk), .reset(reset_b), .stall(stall_b), .redirect(redirect_b),
        .redirect_pc(redirect_pc_b), .imem_pc(imem_pc_b), .imem_instr(imem_instr_b),
        .id_instr(id_instr_b), .id_pc(id_pc_b), .id_pc_plus4(id_pc_plus4_b),
        .id_valid(id_valid_b), .halted(halted_b)
    );

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + {2'b00, pc[31:2]};
    endfunction

    // Memory word k holds 0x1000_0000+k; word 12 becomes the halt word when enabled.
    always @(posedge clk) begin
        imem_instr_a <= (halt_en && imem_pc_a[31:2] == 30'd12) ? 32'hFFFF_FFFF : word_of(imem_pc_a);
        imem_instr_b <= word_of(imem_pc_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] pc4, input logic v, input logic h,
                               input logic [31:0] ipc);
        check({tag, "_instr"}, ins, 32'd0);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_pc4"}, pc4, 32'd0);
        check({tag, "_valid"}, 32'(v), 32'd0);
        check({tag, "_halted"}, 32'(h), 32'd0);
        check({tag, "_imem_pc"}, ipc, 32'd0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_halt_a(input string name, input int budget);
        int k = 0;
        while (!halted_a && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(halted_a), 32'd1);
    endtask

    task automatic wait_halt_b(input string name, input int budget);
        int k = 0;
        while (!halted_b && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(halted_b), 32'd1);
    endtask

    // Decode consumes the presented instruction on any non-reset cycle with stall low.
    always @(negedge clk) begin : mon_a
        logic [31:0] e;
        if (!reset_a && id_valid_a && !stall_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon_a_unexpected: got pc 0x%08h expected none", id_pc_a);
            end else begin
                e = q_a.pop_front();
                check("mon_a_pc", id_pc_a, e);
                check("mon_a_instr", id_instr_a, word_of(e));
                check("mon_a_pc4", id_pc_plus4_a, e + 32'd4);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [31:0] e;
        if (!reset_b && id_valid_b && !stall_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon_b_unexpected: got pc 0x%08h expected none", id_pc_b);
            end else begin
                e = q_b.pop_front();
                check("mon_b_pc", id_pc_b, e);
                check("mon_b_instr", id_instr_b, word_of(e));
                check("mon_b_pc4", id_pc_plus4_b, e + 32'd4);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset_a = 1'b1; stall_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = 32'd0;
        reset_b = 1'b1; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 32'd0;
        step(3);
        check_reset("a_rst", id_instr_a, id_pc_a, id_pc_plus4_a, id_valid_a, halted_a, imem_pc_a);
        check_reset("b_rst", id_instr_b, id_pc_b, id_pc_plus4_b, id_valid_b, halted_b, imem_pc_b);

        // Streaming, stall hold, redirect, redirect+stall
        q_a.push_back(32'h00); q_a.push_back(32'h04); q_a.push_back(32'h08);
        q_a.push_back(32'h0C); q_a.push_back(32'h10); q_a.push_back(32'h2C);
        q_a.push_back(32'h30);
        reset_a = 1'b0;
        step(1); check("t1_lat_valid0", 32'(id_valid_a), 32'd0);
        step(1); check("t1_valid_c2", 32'(id_valid_a), 32'd1); check("t1_pc_c2", id_pc_a, 32'h00);
        step(1); check("t1_pc_c3", id_pc_a, 32'h04);
        step(1); check("t1_pc_c4", id_pc_a, 32'h08);
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t2_frozen_valid", 32'(id_valid_a), 32'd1);
            check("t2_frozen_pc", id_pc_a, 32'h08);
            check("t2_frozen_instr", id_instr_a, 32'h1000_0002);
        end
        stall_a = 1'b0;
        step(1); check("t2_resume_valid", 32'(id_valid_a), 32'd1); check("t2_resume_pc", id_pc_a, 32'h0C);
        step(1); check("t2_pc16", id_pc_a, 32'h10);
        redirect_a = 1'b1; redirect_pc_a = 32'h2E;
        step(1); check("t3_flush1", 32'(id_valid_a), 32'd0);
        redirect_a = 1'b0;
        step(1); check("t3_flush2", 32'(id_valid_a), 32'd0);
        step(1); check("t3_tgt_valid", 32'(id_valid_a), 32'd1); check("t3_tgt_pc", id_pc_a, 32'h2C);
        step(1); check("t3_tgt_pc_next", id_pc_a, 32'h30);
        step(1); check("t4_pre_pc", id_pc_a, 32'h34);
        redirect_a = 1'b1; stall_a = 1'b1; redirect_pc_a = 32'h40;
        q_a.push_back(32'h40); q_a.push_back(32'h44);
        step(1); check("t4_flush1", 32'(id_valid_a), 32'd0);
        redirect_a = 1'b0; stall_a = 1'b0;
        step(1); check("t4_flush2", 32'(id_valid_a), 32'd0);
        step(1); check("t4_tgt_pc", id_pc_a, 32'h40); check("t4_tgt_valid", 32'(id_valid_a), 32'd1);
        step(1); check("t4_tgt_pc_next", id_pc_a, 32'h44);
        step(1);
        reset_a = 1'b1;
        step(1);
        check_reset("a_midrst", id_instr_a, id_pc_a, id_pc_plus4_a, id_valid_a, halted_a, imem_pc_a);
        check("t4_queue_drained", 32'(q_a.size()), 32'd0);

        // Halt word at word 12, then redirect out of HALT
        halt_en = 1'b1;
        for (int i = 0; i < 12; i++) q_a.push_back(32'(i * 4));
        reset_a = 1'b0;
        wait_halt_a("t5_halted", 40);
        check("t5_queue_drained", 32'(q_a.size()), 32'd0);
        check("t5_halt_valid", 32'(id_valid_a), 32'd0);
        step(4);
        check("t5_halted_sticky", 32'(halted_a), 32'd1);
        check("t5_halt_valid_sticky", 32'(id_valid_a), 32'd0);
        for (int i = 0; i < 12; i++) q_a.push_back(32'(i * 4));
        redirect_a = 1'b1; redirect_pc_a = 32'd0;
        step(1);
        redirect_a = 1'b0;
        check("t5_unhalt", 32'(halted_a), 32'd0);
        wait_halt_a("t5_rehalted", 40);
        check("t5_refetch_drained", 32'(q_a.size()), 32'd0);

        // Running off the end of a 4-word memory
        for (int i = 0; i < 4; i++) q_b.push_back(32'(i * 4));
        reset_b = 1'b0;
        step(1); check("t6_lat_valid0", 32'(id_valid_b), 32'd0);
        wait_halt_b("t6_halted", 20);
        check("t6_queue_drained", 32'(q_b.size()), 32'd0);
        check("t6_halt_valid", 32'(id_valid_b), 32'd0);
        check("t6_pc_parked", imem_pc_b, 32'h10);
        q_b.push_back(32'h00);
        redirect_b = 1'b1; redirect_pc_b = 32'd0;
        step(1);
        redirect_b = 1'b0;
        check("t6_unhalt", 32'(halted_b), 32'd0);
        step(2); check("t6_rerun_pc", id_pc_b, 32'h00); check("t6_rerun_valid", 32'(id_valid_b), 32'd1);
        step(1);
        reset_b = 1'b1;
        step(1);
        check_reset("b_midrst", id_instr_b, id_pc_b, id_pc_plus4_b, id_valid_b, halted_b, imem_pc_b);
        check("t6_midrst_drained", 32'(q_b.size()), 32'd0);
        for (int i = 0; i < 4; i++) q_b.push_back(32'(i * 4));
        reset_b = 1'b0;
        wait_halt_b("t6_rehalted", 20);
        check("t6_restart_drained", 32'(q_b.size()), 32'd0);

        step(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
